// File: rtl/irda_mir_rx_ctrl.sv
// irda_mir_rx_ctrl: MIR receive frame controller.
// Forwards received words to the RX data FIFO, closes each frame into an
// 18-bit status word {crc_err, abort, length} held in a small status FIFO,
// aborts on overrun/oversize/break/software request, sequences receiver
// restarts and raises frame/error interrupts.
// Optional build macro IRDA_MIR_RX_FRAMECNT_EN adds frame_cnt_o[7:0], a
// wrapping count of status words stored.
//
// state     | meaning
// DISABLED  | receive off, restart held to the receiver
// IDLE      | waiting for first word or STO
// RECV      | forwarding words of the current frame
// CLOSE     | STO seen, waiting for its falling edge to sample CRC
// RESTART   | one-cycle restart request after an abort

module irda_mir_rx_ctrl #(
  parameter int          SFIFO_AW  = 2,
  parameter logic [15:0] MAX_WORDS = 16'd520
) (
  input  logic        clk,
  input  logic        wb_rst_i,
  input  logic        rx_enable,
  input  logic        sw_abort,
  input  logic        rxw_add_i,
  input  logic [31:0] rxw_dat_i,
  input  logic        mir_sto_i,
  input  logic        mir_crc_err_i,
  input  logic        mir_rx_err_i,
  input  logic [15:0] mir_len_i,
  input  logic        fifo_full_i,
  output logic        fifo_push_o,
  output logic [31:0] fifo_dat_o,
  output logic        mir_restart_o,
  input  logic        sfifo_rd_i,
  output logic [17:0] sfifo_dat_o,
  output logic        sfifo_empty_o,
  output logic        sfifo_ovf_o,
  output logic        irq_frame_o,
  output logic        irq_error_o
`ifdef IRDA_MIR_RX_FRAMECNT_EN
  ,
  output logic [7:0]  frame_cnt_o
`endif
);

  localparam int SFIFO_DEPTH = 1 << SFIFO_AW;

  typedef enum logic [2:0] {
    S_DISABLED,
    S_IDLE,
    S_RECV,
    S_CLOSE,
    S_RESTART
  } state_t;

  state_t              state_q, state_d;
  logic                sto_prev_q, sto_prev_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                push_q, push_d;
  logic [31:0]         dat_q, dat_d;
  logic                restart_q, restart_d;
  logic                irq_frame_q, irq_frame_d;
  logic                irq_error_q, irq_error_d;
  logic                ovf_q, ovf_d;
  logic [SFIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [SFIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SFIFO_AW:0]   count_q, count_d;
  logic [17:0]         mem_q [SFIFO_DEPTH];
`ifdef IRDA_MIR_RX_FRAMECNT_EN
  logic [7:0]          frame_cnt_q, frame_cnt_d;
`endif

  logic        sto_rise, sto_fall;
  logic        in_frame, word_ok, overrun, oversize, abort_req;
  logic        st_wr, st_store, st_rd;
  logic [17:0] st_wdat;

  // Next-state, datapath and status FIFO bookkeeping
  always_comb begin
    state_d     = state_q;
    sto_prev_d  = mir_sto_i;
    len_d       = len_q;
    cnt_d       = cnt_q;
    push_d      = 1'b0;
    dat_d       = dat_q;
    irq_frame_d = 1'b0;
    irq_error_d = 1'b0;
    ovf_d       = ovf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    st_wr       = 1'b0;
    st_wdat     = 18'd0;

    sto_rise  = mir_sto_i & ~sto_prev_q;
    sto_fall  = ~mir_sto_i & sto_prev_q;
    in_frame  = (state_q == S_RECV) || (state_q == S_CLOSE);
    word_ok   = rxw_add_i & ~fifo_full_i;
    overrun   = rxw_add_i & fifo_full_i;
    oversize  = (cnt_q >= MAX_WORDS);
    abort_req = in_frame & (sw_abort | mir_rx_err_i | overrun | oversize);

    if (!rx_enable) begin
      state_d = S_DISABLED;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_DISABLED: state_d = S_IDLE;
        S_IDLE: begin
          // overrun on a first word is ignored: nothing to abort yet
          push_d = word_ok;
          if (sto_rise) begin
            len_d   = mir_len_i;
            state_d = S_CLOSE;
          end else if (word_ok) begin
            state_d = S_RECV;
          end
        end
        S_RECV: begin
          if (abort_req) begin
            st_wr       = 1'b1;
            st_wdat     = {1'b0, 1'b1, mir_len_i};
            irq_error_d = 1'b1;
            state_d     = S_RESTART;
          end else begin
            push_d = word_ok;
            if (sto_rise) begin
              len_d   = mir_len_i;
              state_d = S_CLOSE;
            end
          end
        end
        S_CLOSE: begin
          if (abort_req) begin
            st_wr       = 1'b1;
            st_wdat     = {1'b0, 1'b1, len_q};
            irq_error_d = 1'b1;
            state_d     = S_RESTART;
          end else begin
            push_d = word_ok;
            if (sto_fall) begin
              st_wr       = 1'b1;
              st_wdat     = {mir_crc_err_i, 1'b0, len_q};
              irq_frame_d = ~mir_crc_err_i;
              irq_error_d = mir_crc_err_i;
              state_d     = S_IDLE;
            end
          end
        end
        S_RESTART: state_d = S_IDLE;
        default:   state_d = S_DISABLED;
      endcase
    end

    if (push_d) dat_d = rxw_dat_i;

    // word counter lives only while a frame is open
    if ((state_d != S_RECV) && (state_d != S_CLOSE)) begin
      cnt_d = 16'd0;
    end else if (push_d && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end

    restart_d = (state_d == S_DISABLED) || (state_d == S_RESTART);

    // a read in the same cycle frees a slot for a write into a full FIFO
    st_rd    = sfifo_rd_i & (count_q != '0);
    st_store = st_wr & ((count_q != (SFIFO_AW+1)'(SFIFO_DEPTH)) | st_rd);
    if (st_wr && !st_store) begin
      ovf_d       = 1'b1;
      irq_error_d = 1'b1;
    end
    if (st_store) wr_ptr_d = wr_ptr_q + SFIFO_AW'(1);
    if (st_rd)    rd_ptr_d = rd_ptr_q + SFIFO_AW'(1);
    if (st_store && !st_rd)      count_d = count_q + (SFIFO_AW+1)'(1);
    else if (!st_store && st_rd) count_d = count_q - (SFIFO_AW+1)'(1);

`ifdef IRDA_MIR_RX_FRAMECNT_EN
    frame_cnt_d = frame_cnt_q + {7'd0, st_store};
`endif
  end

  // State, registered outputs and status FIFO storage
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_DISABLED;
      sto_prev_q  <= 1'b0;
      len_q       <= 16'd0;
      cnt_q       <= 16'd0;
      push_q      <= 1'b0;
      dat_q       <= 32'd0;
      restart_q   <= 1'b1;
      irq_frame_q <= 1'b0;
      irq_error_q <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < SFIFO_DEPTH; i++) mem_q[i] <= 18'd0;
`ifdef IRDA_MIR_RX_FRAMECNT_EN
      frame_cnt_q <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      sto_prev_q  <= sto_prev_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      push_q      <= push_d;
      dat_q       <= dat_d;
      restart_q   <= restart_d;
      irq_frame_q <= irq_frame_d;
      irq_error_q <= irq_error_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      if (st_store) mem_q[wr_ptr_q] <= st_wdat;
`ifdef IRDA_MIR_RX_FRAMECNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign fifo_push_o   = push_q;
  assign fifo_dat_o    = dat_q;
  assign mir_restart_o = restart_q;
  assign sfifo_dat_o   = mem_q[rd_ptr_q];
  assign sfifo_empty_o = (count_q == '0);
  assign sfifo_ovf_o   = ovf_q;
  assign irq_frame_o   = irq_frame_q;
  assign irq_error_o   = irq_error_q;
`ifdef IRDA_MIR_RX_FRAMECNT_EN
  assign frame_cnt_o   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_irda_mir_rx_ctrl.sv
// tb_irda_mir_rx_ctrl: directed bench for the MIR receive frame controller.
module tb_irda_mir_rx_ctrl;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        rx_enable, sw_abort, rxw_add_i, mir_sto_i, mir_crc_err_i;
  logic        mir_rx_err_i, fifo_full_i, sfifo_rd_i;
  logic [31:0] rxw_dat_i;
  logic [15:0] mir_len_i;
  logic        fifo_push_o, mir_restart_o, sfifo_empty_o, sfifo_ovf_o;
  logic        irq_frame_o, irq_error_o;
  logic [31:0] fifo_dat_o;
  logic [17:0] sfifo_dat_o;
`ifdef IRDA_MIR_RX_FRAMECNT_EN
  logic [7:0]  frame_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  irda_mir_rx_ctrl dut (
    .clk           (clk),
    .wb_rst_i      (wb_rst_i),
    .rx_enable     (rx_enable),
    .sw_abort      (sw_abort),
    .rxw_add_i     (rxw_add_i),
    .rxw_dat_i     (rxw_dat_i),
    .mir_sto_i     (mir_sto_i),
    .mir_crc_err_i (mir_crc_err_i),
    .mir_rx_err_i  (mir_rx_err_i),
    .mir_len_i     (mir_len_i),
    .fifo_full_i   (fifo_full_i),
    .fifo_push_o   (fifo_push_o),
    .fifo_dat_o    (fifo_dat_o),
    .mir_restart_o (mir_restart_o),
    .sfifo_rd_i    (sfifo_rd_i),
    .sfifo_dat_o   (sfifo_dat_o),
    .sfifo_empty_o (sfifo_empty_o),
    .sfifo_ovf_o   (sfifo_ovf_o),
    .irq_frame_o   (irq_frame_o),
    .irq_error_o   (irq_error_o)
`ifdef IRDA_MIR_RX_FRAMECNT_EN
    ,
    .frame_cnt_o   (frame_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic full);
    rxw_add_i   = 1'b1;
    rxw_dat_i   = d;
    fifo_full_i = full;
    tick();
    rxw_add_i   = 1'b0;
    fifo_full_i = 1'b0;
  endtask

  task automatic close_frame(input logic [15:0] len, input logic crc);
    mir_sto_i = 1'b1;
    mir_len_i = len;
    tick();
    tick();
    mir_sto_i     = 1'b0;
    mir_crc_err_i = crc;
    tick();
    mir_crc_err_i = 1'b0;
  endtask

  task automatic pop();
    sfifo_rd_i = 1'b1;
    tick();
    sfifo_rd_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushes;
    wb_rst_i = 1'b1;
    rx_enable = 0; sw_abort = 0; rxw_add_i = 0; rxw_dat_i = 0; mir_sto_i = 0;
    mir_crc_err_i = 0; mir_rx_err_i = 0; mir_len_i = 0; fifo_full_i = 0; sfifo_rd_i = 0;
    #23;
    chk("rst_restart", mir_restart_o, 1);
    chk("rst_empty", sfifo_empty_o, 1);
    chk("rst_push", fifo_push_o, 0);
    chk("rst_irq", {irq_frame_o, irq_error_o, sfifo_ovf_o}, 0);
    chk("rst_sdat", sfifo_dat_o, 0);
    wb_rst_i = 1'b0;
    tick();
    chk("dis_restart", mir_restart_o, 1);
    rx_enable = 1'b1;
    tick();
    chk("en_restart", mir_restart_o, 0);

    // good frame
    send_word(32'hA000_0001, 0);
    chk("good_w0", {fifo_push_o, fifo_dat_o}, {1'b1, 32'hA000_0001});
    send_word(32'hA000_0002, 0);
    chk("good_w1", {fifo_push_o, fifo_dat_o}, {1'b1, 32'hA000_0002});
    send_word(32'hA000_0003, 0);
    chk("good_w2", {fifo_push_o, fifo_dat_o}, {1'b1, 32'hA000_0003});
    close_frame(16'd12, 1'b0);
    chk("good_irq", {irq_frame_o, irq_error_o}, 2'b10);
    chk("good_stat", sfifo_dat_o, 18'h0000C);
    chk("good_nempty", sfifo_empty_o, 0);
    tick();
    chk("good_irq_pulse", irq_frame_o, 0);
    pop();
    chk("good_pop_empty", sfifo_empty_o, 1);

    // CRC error; third word coincides with STO rising
    send_word(32'hB000_0001, 0);
    send_word(32'hB000_0002, 0);
    mir_sto_i = 1'b1;
    mir_len_i = 16'd12;
    send_word(32'hB000_0003, 0);
    chk("crc_w2_sto", {fifo_push_o, fifo_dat_o}, {1'b1, 32'hB000_0003});
    tick();
    mir_sto_i = 1'b0;
    mir_crc_err_i = 1'b1;
    tick();
    mir_crc_err_i = 1'b0;
    chk("crc_irq", {irq_frame_o, irq_error_o}, 2'b01);
    chk("crc_stat", sfifo_dat_o, 18'h2000C);
    pop();

    // overrun on second word
    mir_len_i = 16'd4;
    send_word(32'hC000_0001, 0);
    send_word(32'hC000_0002, 1);
    chk("ovr_nopush", fifo_push_o, 0);
    chk("ovr_stat", sfifo_dat_o, 18'h10004);
    chk("ovr_irq", {irq_frame_o, irq_error_o}, 2'b01);
    chk("ovr_restart", mir_restart_o, 1);
    tick();
    chk("ovr_restart_1cyc", mir_restart_o, 0);
    pop();

    // break mid-frame, then a normal frame
    mir_len_i = 16'd8;
    send_word(32'hD000_0001, 0);
    send_word(32'hD000_0002, 0);
    mir_rx_err_i = 1'b1;
    tick();
    mir_rx_err_i = 1'b0;
    chk("brk_stat", sfifo_dat_o, 18'h10008);
    chk("brk_restart", mir_restart_o, 1);
    pop();
    chk("brk_restart_off", mir_restart_o, 0);
    send_word(32'hD000_0003, 0);
    chk("brk_next_w", {fifo_push_o, fifo_dat_o}, {1'b1, 32'hD000_0003});
    close_frame(16'd4, 1'b0);
    chk("brk_next_stat", sfifo_dat_o, 18'h00004);
    chk("brk_next_irq", irq_frame_o, 1);
    pop();

    // software abort while closing keeps the latched length
    send_word(32'hE000_0001, 0);
    mir_sto_i = 1'b1;
    mir_len_i = 16'd4;
    tick();
    mir_len_i = 16'd99;
    sw_abort = 1'b1;
    tick();
    sw_abort = 1'b0;
    chk("swab_stat", sfifo_dat_o, 18'h10004);
    chk("swab_restart", mir_restart_o, 1);
    mir_sto_i = 1'b0;
    pop();

    // length-0 frame from IDLE
    close_frame(16'd0, 1'b0);
    chk("zero_nempty", sfifo_empty_o, 0);
    chk("zero_stat", sfifo_dat_o, 18'h00000);
    chk("zero_irq", irq_frame_o, 1);
    pop();

    // oversize: 520 words accepted, 521st triggers abort
    mir_len_i = 16'd2080;
    pushes = 0;
    rxw_add_i = 1'b1;
    for (int i = 0; i < 521; i++) begin
      rxw_dat_i = 32'(i);
      tick();
      if (fifo_push_o) pushes++;
    end
    rxw_add_i = 1'b0;
    chk("big_pushes", 32'(pushes), 520);
    chk("big_stat", sfifo_dat_o, 18'h10820);
    chk("big_irq", irq_error_o, 1);
    chk("big_restart", mir_restart_o, 1);
    pop();

    // status FIFO overflow
    for (int i = 1; i <= 4; i++) close_frame(16'(i), 1'b0);
    chk("sovf_not_yet", sfifo_ovf_o, 0);
    close_frame(16'd5, 1'b0);
    chk("sovf_set", sfifo_ovf_o, 1);
    chk("sovf_irq", {irq_frame_o, irq_error_o}, 2'b11);
    mir_sto_i = 1'b1;
    mir_len_i = 16'd6;
    tick();
    tick();
    mir_sto_i = 1'b0;
    sfifo_rd_i = 1'b1;
    tick();
    sfifo_rd_i = 1'b0;
    chk("sovf_wr_rd_irq", {irq_frame_o, irq_error_o}, 2'b10);
    chk("sovf_sticky", sfifo_ovf_o, 1);
    chk("sovf_pop0", sfifo_dat_o, 18'h00002);
    pop();
    chk("sovf_pop1", sfifo_dat_o, 18'h00003);
    pop();
    chk("sovf_pop2", sfifo_dat_o, 18'h00004);
    pop();
    chk("sovf_pop3", sfifo_dat_o, 18'h00006);
    pop();
    chk("sovf_empty", sfifo_empty_o, 1);
    pop();
    chk("sovf_rd_empty", sfifo_empty_o, 1);

    // rx_enable dropped while closing
    send_word(32'hF000_0001, 0);
    mir_sto_i = 1'b1;
    mir_len_i = 16'd12;
    tick();
    tick();
    mir_sto_i = 1'b0;
    rx_enable = 1'b0;
    tick();
    chk("dis_nostat", sfifo_empty_o, 1);
    chk("dis_ovf_clr", sfifo_ovf_o, 0);
    chk("dis_irq", {irq_frame_o, irq_error_o}, 2'b00);
    chk("dis_restart_on", mir_restart_o, 1);
    tick();
    chk("dis_restart_hold", mir_restart_o, 1);
    rx_enable = 1'b1;
    tick();
    chk("reen_restart", mir_restart_o, 0);
    close_frame(16'd5, 1'b0);
    chk("reen_stat", sfifo_dat_o, 18'h00005);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
